// File: rtl/chu_sample_buf_core.sv
// MMIO slot core: rate-controlled capture of din into a circular buffer that software drains.
// Optional trigger-armed start is enabled by defining SAMPLE_BUF_TRIG_EN.
module chu_sample_buf_core #(
  parameter int W      = 16,
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  output logic [31:0]   rd_data,
  input  logic [31:0]   wr_data,
  input  logic [W-1:0]  din
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_ARMED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic [DIV_W-1:0]    div_reg_q, div_reg_d, period_q, period_d, tick_q, tick_d;
  logic [15:0]         cnt_reg_q, cnt_reg_d, cnt_act_q, cnt_act_d, taken_q, taken_d;
  logic                done_q, done_d, ovf_q, ovf_d;
  logic [W-1:0]        mem_q [DEPTH];

  logic unused_read;
  assign unused_read = read;

  logic wr_en, ctrl_wr, clear, start, stop, pop_wr;
  assign wr_en   = cs & write;
  assign ctrl_wr = wr_en && (addr == 5'd0);
  assign clear   = ctrl_wr && wr_data[1];
  assign start   = ctrl_wr && wr_data[0];
  assign stop    = ctrl_wr && wr_data[2];
  assign pop_wr  = wr_en && (addr == 5'd3);

  logic din0_rise;
`ifdef SAMPLE_BUF_TRIG_EN
  logic din0_prev_q, din0_prev_d;
  assign din0_prev_d = din[0];
  assign din0_rise   = din[0] && !din0_prev_q;
  always_ff @(posedge clk) begin
    if (reset) din0_prev_q <= 1'b0;
    else       din0_prev_q <= din0_prev_d;
  end
`else
  assign din0_rise = 1'b0;
`endif

  // FSM outputs
  logic capturing, push, pop_ok, full, empty, push_acc, drop, last_sample, start_go;

  always_comb begin
    capturing   = (state_q == S_CAPTURE);
    push        = capturing && (tick_q == '0);
    full        = (level_q == (ADDR_W+1)'(DEPTH));
    empty       = (level_q == '0);
    pop_ok      = pop_wr && !empty;
    push_acc    = push && (!full || pop_ok);
    drop        = push && full && !pop_ok;
    last_sample = push && (cnt_act_q != 16'd0) && ((taken_q + 16'd1) == cnt_act_q);
    start_go    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
`ifdef SAMPLE_BUF_TRIG_EN
          if (start) state_d = S_ARMED;
`else
          if (start) state_d = S_CAPTURE;
`endif
        end
        S_CAPTURE: if (stop || last_sample) state_d = S_DONE;
        S_ARMED: begin
          if (stop)           state_d = S_DONE;
          else if (din0_rise) state_d = S_CAPTURE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    div_reg_d = div_reg_q;
    cnt_reg_d = cnt_reg_q;
    period_d  = period_q;
    cnt_act_d = cnt_act_q;
    tick_d    = tick_q;
    taken_d   = taken_q;
    done_d    = done_q;
    ovf_d     = ovf_q;

    if (wr_en && addr == 5'd1)
      div_reg_d = (wr_data[DIV_W-1:0] == '0) ? DIV_W'(1) : wr_data[DIV_W-1:0];
    if (wr_en && addr == 5'd2)
      cnt_reg_d = wr_data[15:0];

    if (capturing) begin
      tick_d = (tick_q == period_q - DIV_W'(1)) ? '0 : tick_q + DIV_W'(1);
      if (push) taken_d = taken_q + 16'd1;
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_acc, pop_ok})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) ovf_d = 1'b1;
      if (start_go) begin
        tick_d    = '0;
        taken_d   = '0;
        period_d  = div_reg_q;
        cnt_act_d = cnt_reg_q;
        done_d    = 1'b0;
      end
      if (state_q != S_DONE && state_d == S_DONE) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      div_reg_q <= DIV_W'(1);
      cnt_reg_q <= 16'd1;
      period_q  <= DIV_W'(1);
      cnt_act_q <= 16'd1;
      tick_q    <= '0;
      taken_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      div_reg_q <= div_reg_d;
      cnt_reg_q <= cnt_reg_d;
      period_q  <= period_d;
      cnt_act_q <= cnt_act_d;
      tick_q    <= tick_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is not reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_acc && !clear && !reset) mem_q[wr_ptr_q] <= din;
  end

  logic [31:0] status;
  always_comb begin
    status = '0;
    status[0] = capturing;
    status[1] = done_q;
    status[2] = ovf_q;
    status[3] = empty;
    status[4] = full;
    status[5] = (state_q == S_ARMED);
    status[8 +: ADDR_W+1] = level_q;
  end

  always_comb begin
    case (addr)
      5'd0:    rd_data = status;
      5'd2:    rd_data = {16'd0, taken_q};
      5'd3:    rd_data = 32'(mem_q[rd_ptr_q]);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_sample_buf_core.sv
// Bench for chu_sample_buf_core (depth 4): directed register traffic, reads checked by a scoreboard monitor.
module tb_chu_sample_buf_core;
  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] rd_data, wr_data;
  logic [15:0] din;
  logic        cnt_en, rd_chk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] msk_q[$];
  string       name_q[$];

  chu_sample_buf_core #(.W(16), .ADDR_W(2), .DIV_W(32)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .rd_data(rd_data), .wr_data(wr_data), .din(din)
  );

  always #5 clk = ~clk;

  // Monitor: compares rd_data against the oldest expectation whenever a read is presented.
  always @(negedge clk) begin
    if (rd_chk) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expectation got=%08h", rd_data);
      end else begin
        logic [31:0] e, m;
        string nm;
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        nm = name_q.pop_front();
        if (((rd_data ^ e) & m) != 32'd0) begin
          n_fail++;
          $display("FAIL %s got=%08h expected=%08h mask=%08h", nm, rd_data, e, m);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (cnt_en) din = din + 16'd1;
  endtask

  task automatic expect_rd(input logic [31:0] e, input logic [31:0] m, input string nm);
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(nm);
    rd_chk = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] e, input logic [31:0] m, input string nm);
    cs = 1'b1; read = 1'b1; addr = a;
    expect_rd(e, m, nm);
    cyc();
    cs = 1'b0; read = 1'b0; rd_chk = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    cyc();
    cs = 1'b0; write = 1'b0;
  endtask

  // POP write while checking the head entry in the same cycle
  task automatic pop_chk(input logic [31:0] e, input string nm);
    cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = 32'd0;
    expect_rd(e, 32'hFFFF_FFFF, nm);
    cyc();
    cs = 1'b0; write = 1'b0; rd_chk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

`ifndef SAMPLE_BUF_TRIG_EN
  // Status seen in cycles T+1..T+10 after start in cycle T with DIV=4, COUNT=3
  logic [31:0] t2_status [10] = '{32'h009, 32'h101, 32'h101, 32'h101, 32'h101,
                                  32'h201, 32'h201, 32'h201, 32'h201, 32'h302};
`endif

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0;
    wr_data = '0; din = '0; cnt_en = 1'b0; rd_chk = 1'b0;
    idle(3);
    reset = 1'b0;

    do_read(5'd0, 32'h0000_0008, 32'hFFFF_FFFF, "reset_status");
    do_read(5'd1, 32'h0, 32'hFFFF_FFFF, "reset_addr1");
    do_read(5'd2, 32'h0, 32'hFFFF_FFFF, "reset_taken");
    do_read(5'd5, 32'h0, 32'hFFFF_FFFF, "unmapped_addr5");

`ifndef SAMPLE_BUF_TRIG_EN
    // Periodic capture: DIV=4, COUNT=3, constant din
    din = 16'h00A5;
    do_write(5'd1, 32'd4);
    do_write(5'd2, 32'd3);
    do_write(5'd0, 32'h1);
    for (int i = 0; i < 10; i++) do_read(5'd0, t2_status[i], 32'hFFFF_FFFF, $sformatf("div4_status_t%0d", i + 1));
    for (int i = 0; i < 3; i++) begin
      do_read(5'd3, 32'h0000_00A5, 32'hFFFF_FFFF, $sformatf("div4_data%0d", i));
      do_write(5'd3, 32'd0);
    end
    do_read(5'd0, 32'h0000_000A, 32'hFFFF_FFFF, "div4_drained_status");
    do_read(5'd2, 32'd3, 32'hFFFF_FFFF, "div4_taken");

    // Overflow: DIV=1, COUNT=6, counting din into depth 4
    do_write(5'd0, 32'h2);
    do_write(5'd1, 32'd1);
    do_write(5'd2, 32'd6);
    din = 16'h0010; cnt_en = 1'b1;
    do_write(5'd0, 32'h1);
    idle(8);
    cnt_en = 1'b0;
    do_read(5'd0, 32'h0000_0416, 32'hFFFF_FFFF, "ovf_status");
    do_read(5'd2, 32'd6, 32'hFFFF_FFFF, "ovf_taken");
    for (int i = 1; i <= 4; i++) begin
      do_read(5'd3, 32'h10 + 32'(i), 32'hFFFF_FFFF, $sformatf("ovf_data%0d", i));
      do_write(5'd3, 32'd0);
    end
    do_read(5'd0, 32'h0000_000E, 32'hFFFF_FFFF, "ovf_drained_status");

    // Continuous capture with a pop every cycle once full
    do_write(5'd0, 32'h2);
    do_write(5'd2, 32'd0);
    din = 16'h0020; cnt_en = 1'b1;
    do_write(5'd0, 32'h1);
    idle(4);
    for (int k = 1; k <= 6; k++) pop_chk(32'h20 + 32'(k), $sformatf("poprun_head%0d", k));
    do_write(5'd0, 32'h4);
    cnt_en = 1'b0;
    idle(1);
    do_read(5'd0, 32'h0000_0410, 32'h0000_0711, "poprun_stopped_status");
    do_read(5'd3, 32'h0000_0027, 32'hFFFF_FFFF, "poprun_head_after_stop");

    // Restart from DONE keeps the full buffer; clear+start then wins as clear
    do_write(5'd0, 32'h1);
    idle(2);
    do_read(5'd0, 32'h0000_0411, 32'hFFFF_FFFB, "restart_busy_full");
    do_write(5'd0, 32'h3);
    for (int i = 0; i < 3; i++) do_read(5'd0, 32'h0000_0008, 32'hFFFF_FFFF, $sformatf("clear_start_status%0d", i));

    // Reset in the middle of a running capture
    do_write(5'd0, 32'h1);
    idle(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    do_read(5'd0, 32'h0000_0008, 32'hFFFF_FFFF, "midrun_reset_status");
`else
    // Armed start waits for a rising edge on din[0]
    do_write(5'd1, 32'd1);
    do_write(5'd2, 32'd1);
    din = 16'h0000;
    do_write(5'd0, 32'h1);
    for (int i = 0; i < 10; i++) do_read(5'd0, 32'h0000_0028, 32'hFFFF_FFFF, $sformatf("armed_wait%0d", i));
    din = 16'h0001;
    do_read(5'd0, 32'h0000_0028, 32'hFFFF_FFFF, "armed_rise_cycle");
    do_read(5'd0, 32'h0000_0009, 32'hFFFF_FFFF, "armed_capture");
    do_read(5'd0, 32'h0000_0102, 32'hFFFF_FFFF, "armed_done");
    do_read(5'd3, 32'h0000_0001, 32'hFFFF_FFFF, "armed_data");
`endif

    idle(2);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
